z16_mem_arbiter: RTL and testbench
==================================

Z16_MEM_ARBITER -- requirements
Module: z16_mem_arbiter

Interface
- REQ-001: Parameter STARVE_LIMIT, default 4. Number of consecutive cycles a waiting instruction-fetch request loses arbitration before it is forced to win. Legal range is 1..15.
- REQ-002: Port i_clk, input, 1 bit. The single clock; all state updates on its rising edge.
- REQ-003: Port i_rst, input, 1 bit. Reset, synchronous and active-high.
- REQ-004: Port i_if_req, input, 1 bit. Instruction-fetch read request.
- REQ-005: Port i_if_addr, input, 16 bits. Instruction-fetch byte address.
- REQ-006: Port o_if_gnt, output, 1 bit. Fetch request accepted this cycle.
- REQ-007: Port o_if_rvalid, output, 1 bit. Fetch read data valid.
- REQ-008: Port o_if_rdata, output, 16 bits. Fetch read data.
- REQ-009: Port i_dm_req, input, 1 bit. Data-memory access request.
- REQ-010: Port i_dm_wen, input, 1 bit. Data access is a write (1) or a read (0).
- REQ-011: Port i_dm_addr, input, 16 bits. Data access address.
- REQ-012: Port i_dm_wdata, input, 16 bits. Data write value.
- REQ-013: Port o_dm_gnt, output, 1 bit. Data request accepted this cycle.
- REQ-014: Port o_dm_rvalid, output, 1 bit. Data read data valid.
- REQ-015: Port o_dm_rdata, output, 16 bits. Data read data.
- REQ-016: Port o_mem_en, output, 1 bit. Shared memory access strobe.
- REQ-017: Port o_mem_wen, output, 1 bit. Shared memory write enable.
- REQ-018: Port o_mem_addr, output, 16 bits. Shared memory address.
- REQ-019: Port o_mem_wdata, output, 16 bits. Shared memory write data.
- REQ-020: Port i_mem_rdata, input, 16 bits. Shared memory read data, valid exactly one cycle after a read strobe.

Function
- REQ-021: At most one access shall be issued per cycle; o_if_gnt and o_dm_gnt shall never both be 1.
- REQ-022: A grant shall be combinational in the cycle of acceptance; o_mem_en is 1 iff either grant is 1.
- REQ-023: o_mem_addr, o_mem_wen and o_mem_wdata shall be muxed from the granted requester. o_mem_wen is 0 for fetch grants; all four outputs are 0 when nothing is granted.
- REQ-024: A requester shall hold its req, addr, wen and wdata stable until it sees gnt. Deasserting req before gnt withdraws the request with no side effect.
- REQ-025: A granted read shall assert the matching rvalid for exactly one cycle, one cycle after the grant, with rdata equal to i_mem_rdata in that cycle. rdata is 0 when rvalid is 0.
- REQ-026: A granted write shall produce no rvalid.
- REQ-027: Back-to-back grants shall be supported with full throughput: a new grant may issue in the same cycle a previous read's rvalid is asserted.
- REQ-028: With only one requester active, that requester shall be granted in the same cycle.
- REQ-029: Default policy is fixed priority to data, with starvation protection:
  - a 4-bit counter r_starve increments each cycle in which i_if_req=1 and o_if_gnt=0;
  - r_starve clears on o_if_gnt=1 or i_if_req=0;
  - r_starve saturates at STARVE_LIMIT;
  - when r_starve==STARVE_LIMIT, the fetch requester wins a simultaneous request.
- REQ-030: When a data grant and a fetch grant compete in the same cycle, exactly one requester shall be granted; the loser is retried the next cycle with no lost state.

Reset
- REQ-031: While i_rst=1, both grants and o_mem_en shall be forced to 0 regardless of requests.
- REQ-032: After a reset cycle, o_if_rvalid=0, o_dm_rvalid=0, r_starve=0 and the round-robin pointer selects data.
- REQ-033: A read granted in the cycle before reset asserts shall not produce rvalid; its pending tag is discarded.

Configuration
- REQ-034: Macro Z16_ARB_ROUND_ROBIN_EN, when defined, shall replace REQ-029 with round-robin arbitration:
  - a 1-bit last-grant pointer r_last records the most recent grant;
  - a simultaneous request is granted to the requester not in r_last;
  - the starvation counter and STARVE_LIMIT are unused;
  - the first simultaneous request after reset goes to data.
- REQ-035: When Z16_ARB_ROUND_ROBIN_EN is undefined, REQ-029 applies and no round-robin logic shall exist.

Verification
- REQ-036: Assert i_rst for 1 cycle with both reqs held at 1 -> gnts, o_mem_en and rvalids are 0 during and immediately after reset.
- REQ-037: Fetch only, addr 0x0010, memory model returns 0xABCD -> o_if_gnt=1 and o_mem_addr=0x0010 in cycle N; o_if_rvalid=1 and o_if_rdata=0xABCD in N+1.
- REQ-038: Both reqs held continuously, STARVE_LIMIT=4, macro undefined -> data granted in cycles 1-4, fetch granted in cycle 5, pattern repeats every 5 cycles.
- REQ-039: Macro defined, both reqs held continuously -> grants alternate D,I,D,I starting with data after reset.
- REQ-040: Data write 0x1234 to 0x0100, then data read of 0x0100 -> write cycle shows o_mem_wen=1 and no rvalid; read returns o_dm_rdata=0x1234 one cycle after its grant.
- REQ-041: Fetch read granted in cycle N, i_rst=1 in cycle N+1 -> o_if_rvalid stays 0 in N+1 and N+2.

Source files
------------

// File: rtl/z16_mem_arbiter.sv
// z16_mem_arbiter
//
// Two-master arbiter in front of one single-ported memory. The instruction
// fetch port is read-only; the data port can read or write. At most one
// access is issued per cycle, and the grant is combinational in the cycle of
// acceptance. Read data returns exactly one cycle after the grant, on the
// rvalid/rdata pair of whichever port issued the read.
//
// Arbitration (default build): fixed priority to data. A fetch request that
// keeps losing is counted in r_starve; once the count reaches STARVE_LIMIT,
// fetch wins the next simultaneous request.
// Arbitration with Z16_ARB_ROUND_ROBIN_EN defined: round-robin between the
// two ports using a one-bit last-grant pointer, data first after reset.
//
// Ports
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_if_req, i_if_addr           fetch request and byte address
//   o_if_gnt                      fetch accepted this cycle
//   o_if_rvalid, o_if_rdata       fetch read return
//   i_dm_req, i_dm_wen            data request, write (1) / read (0)
//   i_dm_addr, i_dm_wdata         data address and write value
//   o_dm_gnt                      data accepted this cycle
//   o_dm_rvalid, o_dm_rdata       data read return
//   o_mem_en, o_mem_wen           shared memory strobe and write enable
//   o_mem_addr, o_mem_wdata       shared memory address and write data
//   i_mem_rdata                   memory read data, one cycle after strobe
module z16_mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_if_req,
    input  logic [15:0] i_if_addr,
    output logic        o_if_gnt,
    output logic        o_if_rvalid,
    output logic [15:0] o_if_rdata,
    input  logic        i_dm_req,
    input  logic        i_dm_wen,
    input  logic [15:0] i_dm_addr,
    input  logic [15:0] i_dm_wdata,
    output logic        o_dm_gnt,
    output logic        o_dm_rvalid,
    output logic [15:0] o_dm_rdata,
    output logic        o_mem_en,
    output logic        o_mem_wen,
    output logic [15:0] o_mem_addr,
    output logic [15:0] o_mem_wdata,
    input  logic [15:0] i_mem_rdata
);

    logic fetch_wins;
    logic if_gnt;
    logic dm_gnt;
    logic if_pend;
    logic dm_pend;

`ifdef Z16_ARB_ROUND_ROBIN_EN
    // 1 = fetch was granted most recently. Resetting to 1 makes the first
    // simultaneous request after reset go to data.
    logic r_last;

    always_comb begin
        fetch_wins = i_if_req && (!i_dm_req || !r_last);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last <= 1'b1;
        end else if (if_gnt) begin
            r_last <= 1'b1;
        end else if (dm_gnt) begin
            r_last <= 1'b0;
        end
    end
`else
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] r_starve;

    always_comb begin
        fetch_wins = i_if_req && (!i_dm_req || (r_starve == LIMIT));
    end

    // Counts cycles a waiting fetch loses; saturates at LIMIT so fetch keeps
    // winning until it is actually granted.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_starve <= 4'd0;
        end else if (!i_if_req || if_gnt) begin
            r_starve <= 4'd0;
        end else if (r_starve != LIMIT) begin
            r_starve <= r_starve + 4'd1;
        end
    end
`endif

    // fetch_wins already implies i_if_req, so the grants are exclusive.
    assign if_gnt = !i_rst && fetch_wins;
    assign dm_gnt = !i_rst && i_dm_req && !fetch_wins;

    // One-deep read tags; the memory returns data the cycle after the strobe.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            if_pend <= 1'b0;
            dm_pend <= 1'b0;
        end else begin
            if_pend <= if_gnt;
            dm_pend <= dm_gnt && !i_dm_wen;
        end
    end

    assign o_if_gnt    = if_gnt;
    assign o_dm_gnt    = dm_gnt;
    assign o_mem_en    = if_gnt || dm_gnt;
    assign o_mem_wen   = dm_gnt && i_dm_wen;
    assign o_mem_addr  = if_gnt ? i_if_addr : (dm_gnt ? i_dm_addr : 16'h0000);
    assign o_mem_wdata = dm_gnt ? i_dm_wdata : 16'h0000;

    // Gating with i_rst drops a read whose tag was set on the edge just
    // before reset asserted.
    assign o_if_rvalid = if_pend && !i_rst;
    assign o_dm_rvalid = dm_pend && !i_rst;
    assign o_if_rdata  = o_if_rvalid ? i_mem_rdata : 16'h0000;
    assign o_dm_rdata  = o_dm_rvalid ? i_mem_rdata : 16'h0000;

endmodule

// File: tb/tb_z16_mem_arbiter.sv
// Directed bench for z16_mem_arbiter with a small behavioural memory that
// returns read data one cycle after the strobe. Inputs change 1 ns after the
// rising edge; outputs are sampled 1 ns later, well away from the edge.
// Expected arbitration pattern follows Z16_ARB_ROUND_ROBIN_EN if defined.
module tb_z16_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [15:0] if_rdata;
    logic        dm_req;
    logic        dm_wen;
    logic [15:0] dm_addr;
    logic [15:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [15:0] dm_rdata;
    logic        mem_en;
    logic        mem_wen;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = 16'h0000;

    logic [15:0] mem [0:1023];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    z16_mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_if_req    (if_req),
        .i_if_addr   (if_addr),
        .o_if_gnt    (if_gnt),
        .o_if_rvalid (if_rvalid),
        .o_if_rdata  (if_rdata),
        .i_dm_req    (dm_req),
        .i_dm_wen    (dm_wen),
        .i_dm_addr   (dm_addr),
        .i_dm_wdata  (dm_wdata),
        .o_dm_gnt    (dm_gnt),
        .o_dm_rvalid (dm_rvalid),
        .o_dm_rdata  (dm_rdata),
        .o_mem_en    (mem_en),
        .o_mem_wen   (mem_wen),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_wen) mem[mem_addr[9:0]] <= mem_wdata;
            else         mem_rdata <= mem[mem_addr[9:0]];
        end
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_fetch(input int i);
`ifdef Z16_ARB_ROUND_ROBIN_EN
        return (i % 2) == 1;
`else
        return (i % 5) == 4;
`endif
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic prev_if;
        logic prev_dm;
        logic e_if;

        for (int k = 0; k < 1024; k++) mem[k] = 16'h0000;
        mem[16'h0010] = 16'hABCD;

        // Reset with both requests held
        rst = 1'b1; if_req = 1'b1; dm_req = 1'b1; dm_wen = 1'b0;
        if_addr = 16'h0010; dm_addr = 16'h0100; dm_wdata = 16'h0000;
        #1;
        chk("rst_if_gnt", if_gnt, 1'b0);
        chk("rst_dm_gnt", dm_gnt, 1'b0);
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_if_rvalid", if_rvalid, 1'b0);
        tick;
        rst = 1'b0; if_req = 1'b0; dm_req = 1'b0;
        #1;
        chk("post_rst_if_rvalid", if_rvalid, 1'b0);
        chk("post_rst_dm_rvalid", dm_rvalid, 1'b0);
        chk("post_rst_mem_en", mem_en, 1'b0);
        chk("idle_mem_addr", mem_addr, 16'h0000);

        // Fetch-only read
        if_req = 1'b1; if_addr = 16'h0010;
        #1;
        chk("if_gnt", if_gnt, 1'b1);
        chk("if_dm_gnt", dm_gnt, 1'b0);
        chk("if_mem_addr", mem_addr, 16'h0010);
        chk("if_mem_wen", mem_wen, 1'b0);
        tick;
        if_req = 1'b0;
        #1;
        chk("if_rvalid", if_rvalid, 1'b1);
        chk("if_rdata", if_rdata, 16'hABCD);
        chk("if_no_dm_rvalid", dm_rvalid, 1'b0);

        // Data write then read-back
        dm_req = 1'b1; dm_wen = 1'b1; dm_addr = 16'h0100; dm_wdata = 16'h1234;
        #1;
        chk("wr_dm_gnt", dm_gnt, 1'b1);
        chk("wr_mem_wen", mem_wen, 1'b1);
        chk("wr_mem_addr", mem_addr, 16'h0100);
        chk("wr_mem_wdata", mem_wdata, 16'h1234);
        tick;
        dm_wen = 1'b0; dm_wdata = 16'h0000;
        #1;
        chk("wr_no_rvalid", dm_rvalid, 1'b0);
        chk("rd_dm_gnt", dm_gnt, 1'b1);
        chk("rd_mem_wen", mem_wen, 1'b0);
        tick;
        dm_req = 1'b0;
        #1;
        chk("rd_dm_rvalid", dm_rvalid, 1'b1);
        chk("rd_dm_rdata", dm_rdata, 16'h1234);
        tick;
        chk("rd_rvalid_one_cycle", dm_rvalid, 1'b0);
        chk("rd_rdata_zero", dm_rdata, 16'h0000);

        // Fetch granted, reset the next cycle: read must be dropped
        if_req = 1'b1; if_addr = 16'h0010;
        #1;
        chk("rstdrop_if_gnt", if_gnt, 1'b1);
        tick;
        rst = 1'b1; if_req = 1'b0;
        #1;
        chk("rstdrop_rvalid_n1", if_rvalid, 1'b0);
        chk("rstdrop_mem_en", mem_en, 1'b0);
        tick;
        rst = 1'b0;
        #1;
        chk("rstdrop_rvalid_n2", if_rvalid, 1'b0);

        // Both held continuously: arbitration pattern and back-to-back returns
        if_req = 1'b1; if_addr = 16'h0010;
        dm_req = 1'b1; dm_wen = 1'b0; dm_addr = 16'h0100;
        prev_if = 1'b0; prev_dm = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            e_if = exp_fetch(i);
            chk($sformatf("pat%0d_if_gnt", i), if_gnt, e_if);
            chk($sformatf("pat%0d_dm_gnt", i), dm_gnt, !e_if);
            chk($sformatf("pat%0d_if_rvalid", i), if_rvalid, prev_if);
            chk($sformatf("pat%0d_dm_rvalid", i), dm_rvalid, prev_dm);
            chk($sformatf("pat%0d_if_rdata", i), if_rdata, prev_if ? 16'hABCD : 16'h0000);
            chk($sformatf("pat%0d_dm_rdata", i), dm_rdata, prev_dm ? 16'h1234 : 16'h0000);
            prev_if = e_if;
            prev_dm = !e_if;
            tick;
        end
        if_req = 1'b0; dm_req = 1'b0;
        #1;
        chk("pat_end_if_rvalid", if_rvalid, prev_if);
        chk("pat_end_dm_rvalid", dm_rvalid, prev_dm);
        chk("pat_end_mem_en", mem_en, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
